// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Generates the instruction fetch PC. Follows predictor hints for
//   conditional branches, remembers each in-flight branch in a small FIFO,
//   and redirects the PC (with a one-cycle flush pulse) when the execute
//   stage resolves the oldest branch differently from how it was predicted.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   stall           downstream not accepting; hold the fetch PC
//   is_branch       instruction at pc is a conditional branch
//   branch_now      predictor says taken for pc
//   pred_target     predicted target for pc
//   resolve_valid   execute resolves the oldest in-flight branch
//   resolve_taken   actual outcome of that branch
//   resolve_target  actual taken target of that branch
//   pc              current fetch PC (word aligned)
//   pc_valid        pc is a valid fetch address
//   flush           registered one-cycle squash pulse
//   q_full          branch queue full
//   upd_valid       predictor update strobe (equals pop)
//   upd_taken       predictor update outcome (equals resolve_taken)
//   mispredict_cnt  running mispredict count (wraps)
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        branch_now,
    input  logic [31:0] pred_target,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        q_full,
    output logic        upd_valid,
    output logic        upd_taken,
    output logic [31:0] mispredict_cnt
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(QDEPTH);

    // Every PC and target is word aligned: the low two bits are dropped.
    function automatic logic [31:0] align4(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Control state
    logic [31:0]   pc_q, pc_d;
    logic          pc_valid_q, pc_valid_d;
    logic          flush_q, flush_d;
    logic [31:0]   mispredict_cnt_q, mispredict_cnt_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   occ_q, occ_d;

    // Queue payload; validity is tracked solely by head/tail/occupancy,
    // so the storage itself needs no reset.
    logic          pred_mem  [QDEPTH];
    logic [31:0]   fall_mem  [QDEPTH];
    logic [31:0]   ptgt_mem  [QDEPTH];

    logic          q_empty;
    logic          q_full_w;
    logic          head_pred;
    logic [31:0]   head_fall;
    logic [31:0]   head_ptgt;
    logic          pop;
    logic          push;
    logic          advance;
    logic          target_miss;
    logic          mispredict;
    logic [31:0]   pc_plus4;

    always_comb begin
        q_empty     = (occ_q == '0);
        q_full_w    = (occ_q == OCC_FULL);
        head_pred   = pred_mem[head_q];
        head_fall   = fall_mem[head_q];
        head_ptgt   = ptgt_mem[head_q];

        // A resolve against an empty queue is stale and ignored entirely.
        pop         = resolve_valid & ~q_empty;
        target_miss = (align4(resolve_target) != head_ptgt);
        mispredict  = pop & ((resolve_taken != head_pred) |
                             (resolve_taken & head_pred & target_miss));

        // A branch may still advance into a full queue when the head is
        // popping in the same cycle, since a slot frees up at that edge.
        advance     = pc_valid_q & ~stall & ~(is_branch & q_full_w & ~pop);
        push        = advance & is_branch & ~mispredict;
        pc_plus4    = pc_q + 32'd4;

        // Redirect beats prediction beats sequential; it ignores stall.
        if (mispredict) begin
            pc_d = resolve_taken ? align4(resolve_target) : head_fall;
        end else if (advance & is_branch & branch_now) begin
            pc_d = align4(pred_target);
        end else if (advance) begin
            pc_d = pc_plus4;
        end else begin
            pc_d = pc_q;
        end

        pc_valid_d       = 1'b1;
        flush_d          = mispredict;
        mispredict_cnt_d = mispredict_cnt_q + {31'b0, mispredict};

        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (mispredict) begin
            // Everything younger than the mispredicted branch is squashed.
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + (AW + 1)'(1);
                2'b01:   occ_d = occ_q - (AW + 1)'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q             <= align4(RESET_PC);
            pc_valid_q       <= 1'b0;
            flush_q          <= 1'b0;
            mispredict_cnt_q <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            occ_q            <= '0;
        end else begin
            pc_q             <= pc_d;
            pc_valid_q       <= pc_valid_d;
            flush_q          <= flush_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            occ_q            <= occ_d;
        end
    end

    // When full with a simultaneous pop, tail equals head: the head entry is
    // read combinationally this cycle and overwritten at the same edge.
    always_ff @(posedge clk) begin
        if (push) begin
            pred_mem[tail_q] <= branch_now;
            fall_mem[tail_q] <= pc_plus4;
            ptgt_mem[tail_q] <= align4(pred_target);
        end
    end

    assign pc             = pc_q;
    assign pc_valid       = pc_valid_q;
    assign flush          = flush_q;
    assign q_full         = q_full_w;
    assign upd_valid      = pop;
    assign upd_taken      = resolve_taken;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    localparam logic [31:0] RPC = 32'h0000_2000;
    localparam int QD = 4;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        is_branch;
    logic        branch_now;
    logic [31:0] pred_target;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        q_full;
    logic        upd_valid;
    logic        upd_taken;
    logic [31:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fetch_pc_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .stall(stall), .is_branch(is_branch),
        .branch_now(branch_now), .pred_target(pred_target),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .pc(pc), .pc_valid(pc_valid),
        .flush(flush), .q_full(q_full), .upd_valid(upd_valid),
        .upd_taken(upd_taken), .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-flight branches as an unbounded queue of records.
    typedef struct {
        bit          pred;
        logic [31:0] fall;
        logic [31:0] ptgt;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_pcv;
    bit          m_flush;

    function automatic logic [31:0] al(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = RPC;
        m_cnt   = 0;
        m_pcv   = 0;
        m_flush = 0;
    endtask

    task automatic model_update();
        bit          pop;
        bit          mis;
        bit          adv;
        logic [31:0] npc;
        ent_t        e;
        pop = resolve_valid && (mq.size() > 0);
        mis = 0;
        if (pop) begin
            if (resolve_taken != mq[0].pred) mis = 1;
            else if (resolve_taken && al(resolve_target) != mq[0].ptgt) mis = 1;
        end
        adv = m_pcv && !stall && !(is_branch && mq.size() == QD && !pop);
        if (mis) npc = resolve_taken ? al(resolve_target) : mq[0].fall;
        else if (adv && is_branch && branch_now) npc = al(pred_target);
        else if (adv) npc = m_pc + 32'd4;
        else npc = m_pc;
        e.pred = branch_now;
        e.fall = m_pc + 32'd4;
        e.ptgt = al(pred_target);
        if (mis) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (adv && is_branch) mq.push_back(e);
        end
        m_flush = mis;
        m_cnt   = m_cnt + (mis ? 32'd1 : 32'd0);
        m_pcv   = 1;
        m_pc    = npc;
    endtask

    // Advance one clock; inputs are held across the edge, results are
    // observable 1 time unit after it.
    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else model_update();
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; is_branch = 0; branch_now = 0; pred_target = 0;
        resolve_valid = 0; resolve_taken = 0; resolve_target = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++; if (pc !== RPC) begin n_errors++; $display("FAIL reset_pc got %h want %h", pc, RPC); end
        n_checks++; if (pc_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pc_valid got %b want 0", pc_valid); end
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush got %b want 0", flush); end
        n_checks++; if (q_full !== 1'b0) begin n_errors++; $display("FAIL reset_q_full got %b want 0", q_full); end
        n_checks++; if (mispredict_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", mispredict_cnt); end
        rst = 1;
        #1;
        n_checks++; if (pc !== 32'h2000) begin n_errors++; $display("FAIL release_pc got %h want 2000", pc); end
    endtask

    task automatic test_sequence();
        logic [31:0] exp_pc [5];
        exp_pc[0] = 32'h2000; exp_pc[1] = 32'h2004; exp_pc[2] = 32'h2008;
        exp_pc[3] = 32'h200C; exp_pc[4] = 32'h2010;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (pc !== exp_pc[i]) begin n_errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, exp_pc[i]); end
            n_checks++; if (pc_valid !== 1'b1) begin n_errors++; $display("FAIL seq_pc_valid[%0d] got %b want 1", i, pc_valid); end
            n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL seq_flush[%0d] got %b want 0", i, flush); end
        end
        // Predicted-taken branch at 0x2010
        is_branch = 1; branch_now = 1; pred_target = 32'h2100;
        step();
        n_checks++; if (pc !== 32'h2100) begin n_errors++; $display("FAIL pred_taken_pc got %h want 2100", pc); end
        // Resolve it not-taken: mispredict back to fallthrough
        clear_inputs();
        resolve_valid = 1; resolve_taken = 0;
        #1;
        n_checks++; if (upd_valid !== 1'b1) begin n_errors++; $display("FAIL resolve_upd_valid got %b want 1", upd_valid); end
        n_checks++; if (upd_taken !== 1'b0) begin n_errors++; $display("FAIL resolve_upd_taken got %b want 0", upd_taken); end
        step();
        n_checks++; if (pc !== 32'h2014) begin n_errors++; $display("FAIL redirect_pc got %h want 2014", pc); end
        n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL redirect_flush got %b want 1", flush); end
        n_checks++; if (mispredict_cnt !== 32'd1) begin n_errors++; $display("FAIL redirect_cnt got %0d want 1", mispredict_cnt); end
        clear_inputs();
        step();
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL flush_width got %b want 0", flush); end
        n_checks++; if (pc !== 32'h2018) begin n_errors++; $display("FAIL post_flush_pc got %h want 2018", pc); end
    endtask

    task automatic test_queue_full();
        clear_inputs();
        is_branch = 1; branch_now = 0;
        for (int i = 0; i < 4; i++) step();
        n_checks++; if (q_full !== 1'b1) begin n_errors++; $display("FAIL full_flag got %b want 1", q_full); end
        n_checks++; if (pc !== 32'h2028) begin n_errors++; $display("FAIL full_pc got %h want 2028", pc); end
        step();
        n_checks++; if (pc !== 32'h2028) begin n_errors++; $display("FAIL full_hold_pc got %h want 2028", pc); end
        resolve_valid = 1; resolve_taken = 0;
        #1;
        n_checks++; if (upd_valid !== 1'b1) begin n_errors++; $display("FAIL full_pop_upd got %b want 1", upd_valid); end
        step();
        n_checks++; if (pc !== 32'h202C) begin n_errors++; $display("FAIL push_pop_full_pc got %h want 202c", pc); end
        n_checks++; if (q_full !== 1'b1) begin n_errors++; $display("FAIL push_pop_full_flag got %b want 1", q_full); end
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL push_pop_flush got %b want 0", flush); end
    endtask

    task automatic test_stall_mispredict();
        clear_inputs();
        resolve_valid = 1; resolve_taken = 0;
        step();
        n_checks++; if (pc !== 32'h2030) begin n_errors++; $display("FAIL drain_pc got %h want 2030", pc); end
        n_checks++; if (q_full !== 1'b0) begin n_errors++; $display("FAIL drain_full got %b want 0", q_full); end
        // Three queued, head predicted not-taken; resolve taken under stall
        stall = 1; is_branch = 1; branch_now = 1; pred_target = 32'h4000;
        resolve_valid = 1; resolve_taken = 1; resolve_target = 32'h3000;
        step();
        n_checks++; if (pc !== 32'h3000) begin n_errors++; $display("FAIL stall_redirect_pc got %h want 3000", pc); end
        n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL stall_redirect_flush got %b want 1", flush); end
        n_checks++; if (mispredict_cnt !== 32'd2) begin n_errors++; $display("FAIL stall_redirect_cnt got %0d want 2", mispredict_cnt); end
    endtask

    task automatic test_empty_resolve();
        clear_inputs();
        resolve_valid = 1; resolve_taken = 1; resolve_target = 32'h5000;
        #1;
        n_checks++; if (upd_valid !== 1'b0) begin n_errors++; $display("FAIL empty_upd_valid got %b want 0", upd_valid); end
        step();
        n_checks++; if (pc !== 32'h3004) begin n_errors++; $display("FAIL empty_pc got %h want 3004", pc); end
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL empty_flush got %b want 0", flush); end
        n_checks++; if (mispredict_cnt !== 32'd2) begin n_errors++; $display("FAIL empty_cnt got %0d want 2", mispredict_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            is_branch     = ($urandom_range(0, 4) < 2);
            branch_now    = $urandom_range(0, 1);
            pred_target   = $urandom;
            resolve_valid = ($urandom_range(0, 4) < 2);
            resolve_taken = $urandom_range(0, 1);
            if (mq.size() > 0 && $urandom_range(0, 2) != 0)
                resolve_target = mq[0].ptgt | 32'($urandom_range(0, 3));
            else
                resolve_target = $urandom;
            #1;
            n_checks++; if (upd_valid !== (resolve_valid && mq.size() > 0)) begin n_errors++; $display("FAIL rnd_upd_valid cyc %0d got %b want %b", i, upd_valid, resolve_valid && mq.size() > 0); end
            n_checks++; if (upd_taken !== resolve_taken) begin n_errors++; $display("FAIL rnd_upd_taken cyc %0d got %b want %b", i, upd_taken, resolve_taken); end
            n_checks++; if (q_full !== (mq.size() == QD)) begin n_errors++; $display("FAIL rnd_q_full cyc %0d got %b want %b", i, q_full, mq.size() == QD); end
            step();
            n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); end
            n_checks++; if (pc_valid !== m_pcv) begin n_errors++; $display("FAIL rnd_pc_valid cyc %0d got %b want %b", i, pc_valid, m_pcv); end
            n_checks++; if (flush !== m_flush) begin n_errors++; $display("FAIL rnd_flush cyc %0d got %b want %b", i, flush, m_flush); end
            n_checks++; if (mispredict_cnt !== m_cnt) begin n_errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, mispredict_cnt, m_cnt); end
        end
    endtask

    task automatic test_reset_midop();
        clear_inputs();
        is_branch = 1; branch_now = 1; pred_target = 32'h6000;
        resolve_valid = 1; resolve_taken = 1; resolve_target = 32'h0;
        if (!q_full) resolve_valid = 0;
        step();
        clear_inputs();
        // Queue now holds at least one entry; resolve the head wrongly.
        resolve_valid = 1;
        resolve_taken = (mq.size() > 0) ? !mq[0].pred : 1'b0;
        resolve_target = 32'h7000;
        step();
        n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL midop_flush_set got %b want 1", flush); end
        clear_inputs();
        is_branch = 1; branch_now = 0;
        step();
        #2;
        rst = 0;
        #1;
        n_checks++; if (pc !== RPC) begin n_errors++; $display("FAIL midop_pc got %h want %h", pc, RPC); end
        n_checks++; if (pc_valid !== 1'b0) begin n_errors++; $display("FAIL midop_pc_valid got %b want 0", pc_valid); end
        n_checks++; if (q_full !== 1'b0) begin n_errors++; $display("FAIL midop_q_full got %b want 0", q_full); end
        n_checks++; if (mispredict_cnt !== 32'd0) begin n_errors++; $display("FAIL midop_cnt got %0d want 0", mispredict_cnt); end
        model_reset();
        clear_inputs();
        step();
        rst = 1;
        resolve_valid = 1; resolve_taken = 1;
        #1;
        n_checks++; if (upd_valid !== 1'b0) begin n_errors++; $display("FAIL midop_queue_empty got %b want 0", upd_valid); end
        step();
        n_checks++; if (pc !== RPC || flush !== 1'b0) begin n_errors++; $display("FAIL midop_first_edge pc %h flush %b want %h 0", pc, flush, RPC); end
        clear_inputs();
        step();
        n_checks++; if (pc !== RPC + 32'd4) begin n_errors++; $display("FAIL midop_advance got %h want %h", pc, RPC + 32'd4); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_queue_full();
        test_stall_mispredict();
        test_empty_resolve();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
